// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: width codes, FSM states and
// the fill word returned when a read times out.
package mem_arbiter_pkg;

  // Data width codes presented on mem_data_width.
  localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
  localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
  localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
  localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

  // Read data substituted when the controller never answers.
  localparam logic [31:0] TIMEOUT_FILL  = 32'hDEAD_BEEF;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational N-wide request picker, fixed priority or round-robin.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to act on winner/found.
// Ports: req (requests), rr_ptr (last granted index), mode (0 fixed, 1 rr),
//        winner (selected index), found (any request present).
module arb_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic          mode,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW-1:0] cand;

  // Walk the candidates in priority order and keep the first hit. In
  // round-robin mode the search starts just after the last granted index.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      if (mode) begin
        cand = IW'((int'(rr_ptr) + 1 + k) % N);
      end else begin
        cand = IW'(k);
      end
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-channel read/write arbiter onto the single memory controller port.
// Latency: write request to ch_wr_done 3 cycles; read 3 cycles + controller latency.
// Backpressure: holds in ISSUE while ready is low; re-issues if ready drops after a strobe.
// Ports: ch_* flattened per-channel requests/addr/width/data plus per-channel pulses,
//        grant/busy status, mem_* controller issue/response port.
// Optional: ARB_TIMEOUT_EN adds a 16-bit read timeout and the sticky timeout_err output.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int              N_CH      = 2,
  parameter int              ADDR_W    = 26,
  parameter int              DATA_W    = 32,
  parameter int              ARB_MODE  = 0,
  parameter logic [N_CH-1:0] HOLD_MASK = N_CH'(1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_rd,
  input  logic [N_CH-1:0]          ch_wr,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr,
  input  logic [N_CH*2-1:0]        ch_width,
  input  logic [N_CH*DATA_W-1:0]   ch_wr_data,
  output logic [DATA_W-1:0]        ch_rd_data,
  output logic [N_CH-1:0]          ch_rd_valid,
  output logic [N_CH-1:0]          ch_wr_done,
  output logic [$clog2(N_CH)-1:0]  grant,
  output logic                     busy,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic                     mem_rd_ready,
  input  logic                     mem_wr_ready,
  input  logic                     mem_rd_valid,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [1:0]               mem_data_width,
  output logic [DATA_W-1:0]        mem_wr_data
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int GW = $clog2(N_CH);

  state_t        state;
  logic          op_rd;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic          found;
`ifdef ARB_TIMEOUT_EN
  logic [15:0]   wait_cnt;
`endif

  arb_pick #(
    .N  (N_CH),
    .IW (GW)
  ) u_pick (
    .req    (ch_rd | ch_wr),
    .rr_ptr (rr_ptr),
    .mode   (ARB_MODE != 0),
    .winner (winner),
    .found  (found)
  );

  assign busy = (state != S_IDLE);

  // The arbiter does not latch channel inputs; the granted channel's live
  // address/width/data are steered straight through.
  always_comb begin
    mem_addr       = '0;
    mem_data_width = DATA_WIDTH_0;
    mem_wr_data    = '0;
    if (state != S_IDLE) begin
      mem_addr       = ch_addr[grant*ADDR_W +: ADDR_W];
      mem_data_width = ch_width[grant*2 +: 2];
    end
    if (ch_wr[grant]) begin
      mem_wr_data = ch_wr_data[grant*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      op_rd       <= 1'b0;
      rr_ptr      <= GW'(N_CH - 1);
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      ch_rd_valid <= '0;
      ch_wr_done  <= '0;
      ch_rd_data  <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      ch_rd_valid <= '0;
      ch_wr_done  <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant  <= winner;
            op_rd  <= ch_rd[winner];  // read wins when both are set
            rr_ptr <= winner;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_rd ? mem_rd_ready : mem_wr_ready) begin
            mem_rd   <= op_rd;
            mem_wr   <= !op_rd;
            state    <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A strobe is still visible on mem_rd/mem_wr only in the first WAIT
          // cycle; ready low there means the controller refused the issue.
          if ((mem_rd && !mem_rd_ready) || (mem_wr && !mem_wr_ready)) begin
            state <= S_ISSUE;
          end else if (!op_rd) begin
            ch_wr_done[grant] <= 1'b1;
            state             <= S_DONE;
          end else if (mem_rd_valid) begin
            ch_rd_data         <= mem_rd_data;
            ch_rd_valid[grant] <= 1'b1;
            state              <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LIMIT) begin
            ch_rd_data         <= DATA_W'(TIMEOUT_FILL);
            ch_rd_valid[grant] <= 1'b1;
            timeout_err        <= 1'b1;
            state              <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        S_DONE: begin
          state <= HOLD_MASK[grant] ? S_RELEASE : S_IDLE;
        end
        S_RELEASE: begin
          if (!ch_rd[grant] && !ch_wr[grant]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-channel fixed-priority instance (cart hold on ch0)
// checked every cycle against a transaction-level model plus directed cases,
// and a 4-channel round-robin instance checked for grant order.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents seen by the bench controller: a fixed function of address.
  function automatic logic [31:0] mem_val(input logic [25:0] ad);
    return {6'h2A, ad} ^ 32'h0F0F_0F0F;
  endfunction

  // ---------------- instance A: N_CH=2, fixed priority, hold on ch0 ----------
  logic [1:0]  a_rd, a_wr;
  logic [25:0] a_addr [2];
  logic [1:0]  a_width [2];
  logic [31:0] a_wdata [2];
  logic [51:0] a_addr_f;
  logic [3:0]  a_width_f;
  logic [63:0] a_wdata_f;
  logic [31:0] a_ch_rd_data;
  logic [1:0]  a_rd_valid, a_wr_done;
  logic [0:0]  a_grant;
  logic        a_busy, a_mem_rd, a_mem_wr;
  logic        a_rd_rdy, a_wr_rdy, a_mrv;
  logic [31:0] a_mrd;
  logic [25:0] a_mem_addr;
  logic [1:0]  a_mem_width;
  logic [31:0] a_mem_wdata;
  logic        a_terr;

  assign a_addr_f  = {a_addr[1], a_addr[0]};
  assign a_width_f = {a_width[1], a_width[0]};
  assign a_wdata_f = {a_wdata[1], a_wdata[0]};

  mem_arbiter #(
    .N_CH(2), .ADDR_W(26), .DATA_W(32), .ARB_MODE(0), .HOLD_MASK(2'b01)
  ) dut_a (
    .clk(clk), .rst(rst),
    .ch_rd(a_rd), .ch_wr(a_wr), .ch_addr(a_addr_f), .ch_width(a_width_f),
    .ch_wr_data(a_wdata_f), .ch_rd_data(a_ch_rd_data), .ch_rd_valid(a_rd_valid),
    .ch_wr_done(a_wr_done), .grant(a_grant), .busy(a_busy),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_rd_ready(a_rd_rdy),
    .mem_wr_ready(a_wr_rdy), .mem_rd_valid(a_mrv), .mem_rd_data(a_mrd),
    .mem_addr(a_mem_addr), .mem_data_width(a_mem_width), .mem_wr_data(a_mem_wdata)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(a_terr)
`endif
  );

  // ---------------- instance B: N_CH=4, round-robin, no hold -----------------
  logic [3:0]   b_rd, b_wr;
  logic [103:0] b_addr_f;
  logic [7:0]   b_width_f;
  logic [127:0] b_wdata_f;
  logic [31:0]  b_ch_rd_data;
  logic [3:0]   b_rd_valid, b_wr_done;
  logic [1:0]   b_grant;
  logic         b_busy, b_mem_rd, b_mem_wr;
  logic         b_rd_rdy, b_wr_rdy, b_mrv;
  logic [31:0]  b_mrd;
  logic [25:0]  b_mem_addr;
  logic [1:0]   b_mem_width;
  logic [31:0]  b_mem_wdata;
  logic         b_terr;

  mem_arbiter #(
    .N_CH(4), .ADDR_W(26), .DATA_W(32), .ARB_MODE(1), .HOLD_MASK(4'b0000)
  ) dut_b (
    .clk(clk), .rst(rst),
    .ch_rd(b_rd), .ch_wr(b_wr), .ch_addr(b_addr_f), .ch_width(b_width_f),
    .ch_wr_data(b_wdata_f), .ch_rd_data(b_ch_rd_data), .ch_rd_valid(b_rd_valid),
    .ch_wr_done(b_wr_done), .grant(b_grant), .busy(b_busy),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_rd_ready(b_rd_rdy),
    .mem_wr_ready(b_wr_rdy), .mem_rd_valid(b_mrv), .mem_rd_data(b_mrd),
    .mem_addr(b_mem_addr), .mem_data_width(b_mem_width), .mem_wr_data(b_mem_wdata)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(b_terr)
`endif
  );

  // ---------------- memory controller for A: fixed read latency --------------
  int          rd_cnt = 0;
  int          rd_lat = 2;
  logic        no_resp = 1'b0;
  logic [25:0] pend_addr = '0;

  always @(negedge clk) begin
    a_mrv = 1'b0;
    if (rst) begin
      rd_cnt = 0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          a_mrv = 1'b1;
          a_mrd = mem_val(pend_addr);
        end
      end
      if (a_mem_rd && !no_resp) begin
        rd_cnt    = rd_lat;
        pend_addr = a_mem_addr;
      end
    end
  end

  // ---------------- transaction model and per-cycle compare for A ------------
  // Each busy period is one transaction: the winner is the lowest requesting
  // index at the start, the port shows that channel's inputs, and exactly one
  // pulse of the right kind arrives on that channel before the next grant.
  logic       prev_busy = 1'b0;
  logic [1:0] prev_req = '0;
  logic [1:0] prev_rdreq = '0;
  int         m_g = 0;
  int         exp_g;
  logic       m_out = 1'b0;
  logic       m_op_rd = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      m_out     = 1'b0;
    end else begin
      check("strobe_exclusive", 32'(a_mem_rd & a_mem_wr), 32'd0);
      if (!a_busy) begin
        check("idle_mem_addr", 32'(a_mem_addr), 32'd0);
        check("idle_mem_width", 32'(a_mem_width), 32'd0);
      end
      if (a_busy && !prev_busy) begin
        exp_g = prev_req[0] ? 0 : 1;
        check("grant_pick", 32'(a_grant), 32'(exp_g));
        check("prev_txn_closed", 32'(m_out), 32'd0);
        m_g     = exp_g;
        m_out   = 1'b1;
        m_op_rd = prev_rdreq[exp_g];
      end
      if (a_busy) begin
        check("mem_addr", 32'(a_mem_addr), 32'(a_addr[m_g]));
        check("mem_width", 32'(a_mem_width), 32'(a_width[m_g]));
        check("mem_wr_data", a_mem_wdata, a_wr[m_g] ? a_wdata[m_g] : 32'd0);
      end
      if (a_rd_valid != 2'b00 || a_wr_done != 2'b00) begin
        check("pulse_in_txn", 32'(m_out), 32'd1);
        check("rd_valid_vec", 32'(a_rd_valid), m_op_rd ? 32'(1 << m_g) : 32'd0);
        check("wr_done_vec", 32'(a_wr_done), m_op_rd ? 32'd0 : 32'(1 << m_g));
        if (m_op_rd) begin
          check("rd_data", a_ch_rd_data, no_resp ? 32'hDEAD_BEEF : mem_val(a_addr[m_g]));
        end
        m_out = 1'b0;
      end
      prev_busy  = a_busy;
      prev_req   = a_rd | a_wr;
      prev_rdreq = a_rd;
    end
  end

  // ---------------- directed stimulus ----------------------------------------
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    int cyc;
    int strobes;
    int dones;
    int low_cnt;
    logic seen;

    a_rd = '0; a_wr = '0; a_rd_rdy = 1'b1; a_wr_rdy = 1'b1; a_mrd = '0;
    for (int i = 0; i < 2; i++) begin
      a_addr[i] = '0; a_width[i] = '0; a_wdata[i] = '0;
    end
    b_rd = '0; b_wr = '0; b_rd_rdy = 1'b1; b_wr_rdy = 1'b1; b_mrv = 1'b0; b_mrd = '0;
    b_addr_f = {26'h30, 26'h20, 26'h10, 26'h00};
    b_width_f = 8'hFF;
    b_wdata_f = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

    rst = 1'b1;
    repeat (3) tick();
    // Reset state
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_grant", 32'(a_grant), 32'd0);
    check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    check("rst_wr_done", 32'(a_wr_done), 32'd0);
    check("rst_rd_data", a_ch_rd_data, 32'd0);
    check("rst_strobes", 32'({a_mem_rd, a_mem_wr}), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    check("rst_b_grant", 32'(b_grant), 32'd0);
`ifdef ARB_TIMEOUT_EN
    check("rst_timeout_err", 32'(a_terr), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Single read on channel 1, controller latency 2
    a_addr[1] = 26'h0000100; a_width[1] = 2'b11; a_rd[1] = 1'b1;
    cyc = 0; strobes = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      tick(); cyc++;
      if (a_mem_rd) begin
        strobes++;
        check("t1_mem_addr", 32'(a_mem_addr), 32'h0000100);
        check("t1_mem_width", 32'(a_mem_width), 32'd3);
      end
      if (a_rd_valid[1]) seen = 1'b1;
    end
    a_rd[1] = 1'b0;
    check("t1_seen", 32'(seen), 32'd1);
    check("t1_latency", 32'(cyc), 32'd5);
    check("t1_strobes", 32'(strobes), 32'd1);
    check("t1_data", a_ch_rd_data, 32'hA70F_0E0F);
    repeat (3) tick();
    check("t1_idle", 32'(a_busy), 32'd0);

    // Simultaneous reads: ch0 first, ch1 blocked while ch0 holds
    a_addr[0] = 26'h0002000; a_width[0] = 2'b10; a_rd = 2'b11;
    cyc = 0;
    while (a_rd_valid == 2'b00 && cyc < 20) begin tick(); cyc++; end
    check("t2_first", 32'(a_rd_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_hold_busy", 32'(a_busy), 32'd1);
      check("t2_hold_grant", 32'(a_grant), 32'd0);
      check("t2_hold_nopulse", 32'(a_rd_valid), 32'd0);
    end
    a_rd[0] = 1'b0;
    cyc = 0;
    while (a_rd_valid == 2'b00 && cyc < 20) begin tick(); cyc++; end
    a_rd[1] = 1'b0;
    check("t2_second", 32'(a_rd_valid), 32'd2);
    repeat (3) tick();

    // Clean write on ch0 at the top address
    a_addr[0] = 26'h3FF_FFFF; a_width[0] = 2'b01; a_wdata[0] = 32'hCAFE_0001; a_wr[0] = 1'b1;
    cyc = 0;
    while (a_wr_done == 2'b00 && cyc < 20) begin
      tick(); cyc++;
      if (a_mem_wr) check("t3_wdata", a_mem_wdata, 32'hCAFE_0001);
    end
    a_wr[0] = 1'b0;
    check("t3_done", 32'(a_wr_done), 32'd1);
    check("t3_latency", 32'(cyc), 32'd3);
    repeat (3) tick();

    // Write rejected: ready drops the cycle after mem_wr
    a_addr[1] = 26'h55; a_width[1] = 2'b00; a_wdata[1] = 32'h1234_5678; a_wr[1] = 1'b1;
    strobes = 0; dones = 0; low_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (!a_wr_rdy) begin
        low_cnt++;
        if (low_cnt == 3) a_wr_rdy = 1'b1;
      end
      if (a_mem_wr) begin
        strobes++;
        check("t4_wdata", a_mem_wdata, 32'h1234_5678);
        if (strobes == 1) a_wr_rdy = 1'b0;
      end
      if (a_wr_done != 2'b00) begin
        dones++;
        a_wr[1] = 1'b0;
      end
    end
    check("t4_strobes", 32'(strobes), 32'd2);
    check("t4_dones", 32'(dones), 32'd1);

    // Request dropped mid-transaction still completes
    a_addr[1] = 26'h77; a_rd[1] = 1'b1;
    tick(); tick();
    a_rd[1] = 1'b0;
    cyc = 0;
    while (a_rd_valid == 2'b00 && cyc < 20) begin tick(); cyc++; end
    check("t5_pulse", 32'(a_rd_valid), 32'd2);
    check("t5_data", a_ch_rd_data, 32'hA70F_0F78);
    repeat (3) tick();

    // Round-robin on B, all four channels writing continuously
    b_wr = 4'hF;
    dones = 0; cyc = 0;
    while (dones < 5 && cyc < 100) begin
      tick(); cyc++;
      if (b_wr_done != 4'h0) begin
        check("rr_grant", 32'(b_grant), 32'(rr_exp[dones]));
        check("rr_done_vec", 32'(b_wr_done), 32'(1 << rr_exp[dones]));
        dones++;
      end
    end
    b_wr = 4'h0;
    check("rr_count", 32'(dones), 32'd5);

`ifdef ARB_TIMEOUT_EN
    // Controller never answers: timeout fill, sticky error until reset
    repeat (3) tick();
    no_resp = 1'b1;
    a_addr[1] = 26'h99; a_rd[1] = 1'b1;
    cyc = 0;
    while (a_rd_valid == 2'b00 && cyc < 70000) begin tick(); cyc++; end
    a_rd[1] = 1'b0;
    check("to_pulse", 32'(a_rd_valid), 32'd2);
    check("to_window", 32'(cyc >= 65536 && cyc <= 65540), 32'd1);
    check("to_data", a_ch_rd_data, 32'hDEAD_BEEF);
    check("to_err", 32'(a_terr), 32'd1);
    repeat (5) tick();
    check("to_err_sticky", 32'(a_terr), 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    no_resp = 1'b0;
    check("to_err_cleared", 32'(a_terr), 32'd0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
